// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: edge-locked bit timing, NRZI decode, bit unstuffing, LSB-first byte assembly, EOP detection.
// Optional define RX_SYNC_CHECK_EN: the first byte of each packet must be SYNC (0x80) and is consumed silently.
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       eop,
    output logic       rx_err,
    output logic       rx_active
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_EOP  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]        state;
    logic              d_plus_q;
    logic              prev_level;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_cnt;
    logic [ONES_W-1:0] ones_cnt;
    logic [1:0]        se0_cnt;
    logic [2:0]        j_cnt;
    logic              se0_seen;
    logic [7:0]        shift_reg;
`ifdef RX_SYNC_CHECK_EN
    logic              first_byte;
`endif

    logic       edge_det;
    logic       strobe;
    logic       se0;
    logic       dec_bit;
    logic [7:0] next_byte;

    assign edge_det  = d_plus_sync ^ d_plus_q;
    assign strobe    = (cnt == CNT_MID);
    assign se0       = !d_plus_sync && !d_minus_sync;
    assign dec_bit   = (d_plus_sync == prev_level);
    assign next_byte = {dec_bit, shift_reg[7:1]};

    // Bit timer: every line edge re-centres the sampling point half a bit later.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_plus_q <= 1'b1;
            cnt      <= '0;
        end else begin
            d_plus_q <= d_plus_sync;
            if (edge_det || cnt == CNT_MAX)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_RECV && strobe && !se0 && ones_cnt != ONES_MAX)
            shift_reg <= next_byte;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            prev_level <= 1'b1;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            se0_cnt    <= '0;
            j_cnt      <= '0;
            se0_seen   <= 1'b0;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
            eop        <= 1'b0;
            rx_err     <= 1'b0;
            rx_active  <= 1'b0;
`ifdef RX_SYNC_CHECK_EN
            first_byte <= 1'b1;
`endif
        end else begin
            byte_valid <= 1'b0;
            eop        <= 1'b0;
            rx_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (edge_det && !d_plus_sync && d_minus_sync) begin
                        state      <= ST_RECV;
                        rx_active  <= 1'b1;
                        prev_level <= 1'b1;
                        bit_cnt    <= '0;
                        ones_cnt   <= '0;
                        se0_cnt    <= '0;
                        j_cnt      <= '0;
                        se0_seen   <= 1'b0;
`ifdef RX_SYNC_CHECK_EN
                        first_byte <= 1'b1;
`endif
                    end
                end
                ST_RECV: begin
                    if (strobe) begin
                        if (se0) begin
                            state   <= ST_EOP;
                            se0_cnt <= 2'd1;
                            bit_cnt <= '0;
                            if (bit_cnt != 3'd0)
                                rx_err <= 1'b1;
                        end else begin
                            prev_level <= d_plus_sync;
                            if (ones_cnt == ONES_MAX) begin
                                // After a full run of ones only a stuffed 0 is legal.
                                if (dec_bit) begin
                                    rx_err <= 1'b1;
                                    state  <= ST_ERR;
                                end else begin
                                    ones_cnt <= '0;
                                end
                            end else begin
                                ones_cnt <= dec_bit ? ones_cnt + 1'b1 : '0;
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt <= '0;
`ifdef RX_SYNC_CHECK_EN
                                    first_byte <= 1'b0;
                                    if (!first_byte) begin
                                        rx_byte    <= next_byte;
                                        byte_valid <= 1'b1;
                                    end else if (next_byte != 8'h80) begin
                                        rx_err <= 1'b1;
                                        state  <= ST_ERR;
                                    end
`else
                                    rx_byte    <= next_byte;
                                    byte_valid <= 1'b1;
`endif
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (strobe) begin
                        if (se0) begin
                            if (se0_cnt == 2'd2) begin
                                rx_err <= 1'b1;
                                state  <= ST_ERR;
                            end else begin
                                se0_cnt <= se0_cnt + 1'b1;
                            end
                        end else if (d_plus_sync) begin
                            eop       <= 1'b1;
                            state     <= ST_IDLE;
                            rx_active <= 1'b0;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= ST_ERR;
                        end
                    end
                end
                default: begin
                    // Recovery waits for a long idle J run or an SE0-then-J ending.
                    if (strobe) begin
                        if (se0) begin
                            se0_seen <= 1'b1;
                            j_cnt    <= '0;
                        end else if (d_plus_sync) begin
                            if (se0_seen || j_cnt == 3'd7) begin
                                state     <= ST_IDLE;
                                rx_active <= 1'b0;
                            end else begin
                                j_cnt <= j_cnt + 1'b1;
                            end
                        end else begin
                            j_cnt    <= '0;
                            se0_seen <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Bench for usb_rx_bit_decoder: packets are built from byte lists (stuffing + NRZI), and the decoder's
// pulse events are compared against the events predicted while building each packet.
`timescale 1ns/1ps
module tb_usb_rx_bit_decoder;
    localparam int CPB = 8;
    localparam int SL  = 6;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam int EV_BYTE = 1;
    localparam int EV_EOP  = 2;
    localparam int EV_ERR  = 3;
    localparam int EV_IDLE = 4;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    logic       clk          = 1'b0;
    logic       n_rst        = 1'b0;
    logic       d_plus_sync  = 1'b1;
    logic       d_minus_sync = 1'b0;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       eop;
    logic       rx_err;
    logic       rx_active;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    ev_t  got_q[$];
    ev_t  exp_q[$];
    logic [1:0] sym_q[$];
    logic level;
    int   ones;

    usb_rx_bit_decoder #(.CLKS_PER_BIT(CPB), .STUFF_LEN(SL)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .rx_byte      (rx_byte),
        .byte_valid   (byte_valid),
        .eop          (eop),
        .rx_err       (rx_err),
        .rx_active    (rx_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Event monitor, sampled on the inactive edge.
    logic prev_bv = 1'b0, prev_eop = 1'b0, prev_err = 1'b0, prev_act = 1'b0;
    always @(negedge clk) begin
        if (byte_valid) begin
            check("byte_valid_width", int'(prev_bv), 0);
            got_q.push_back('{EV_BYTE, int'(rx_byte), cyc});
        end
        if (eop) begin
            check("eop_width", int'(prev_eop), 0);
            got_q.push_back('{EV_EOP, 0, cyc});
        end
        if (rx_err) begin
            check("rx_err_width", int'(prev_err), 0);
            got_q.push_back('{EV_ERR, 0, cyc});
        end
        if (prev_act && !rx_active)
            got_q.push_back('{EV_IDLE, 0, cyc});
        prev_bv  = byte_valid;
        prev_eop = eop;
        prev_err = rx_err;
        prev_act = rx_active;
    end

    task automatic new_pkt();
        sym_q.delete();
        level = 1'b1;
        ones  = 0;
    endtask

    task automatic nrzi_bit(input logic b);
        if (!b) level = ~level;
        sym_q.push_back(level ? SYM_J : SYM_K);
    endtask

    task automatic data_bit(input logic b);
        nrzi_bit(b);
        ones = b ? ones + 1 : 0;
        if (ones == SL) begin
            nrzi_bit(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic deliver);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            nrzi_bit(v[i]);
            idx  = sym_q.size() - 1;
            ones = v[i] ? ones + 1 : 0;
            if (ones == SL) begin
                nrzi_bit(1'b0);
                ones = 0;
            end
        end
        if (deliver) exp_q.push_back('{EV_BYTE, int'(v), idx});
    endtask

    task automatic send_sync();
`ifdef RX_SYNC_CHECK_EN
        send_byte(8'h80, 1'b0);
`else
        send_byte(8'h80, 1'b1);
`endif
    endtask

    task automatic send_eop();
        sym_q.push_back(SYM_SE0);
        sym_q.push_back(SYM_SE0);
        sym_q.push_back(SYM_J);
        exp_q.push_back('{EV_EOP, 0, sym_q.size() - 1});
        exp_q.push_back('{EV_IDLE, 0, sym_q.size() - 1});
        level = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) sym_q.push_back(SYM_J);
    endtask

    // Drive the symbol list; jitter moves each bit boundary by -1..+1 cycles around nominal.
    task automatic play(input bit jitter);
        int bnd[$];
        logic [1:0] wave[$];
        int p;
        for (int k = 0; k <= sym_q.size(); k++)
            bnd.push_back(k * CPB + ((jitter && k > 0 && k < sym_q.size()) ? int'($urandom_range(2)) - 1 : 0));
        for (int k = 0; k < sym_q.size(); k++)
            for (int c = bnd[k]; c < bnd[k+1]; c++) wave.push_back(sym_q[k]);
        @(posedge clk); #1;
        p = cyc;
        foreach (wave[w]) begin
            {d_plus_sync, d_minus_sync} = wave[w];
            @(posedge clk); #1;
        end
        foreach (exp_q[i])
            exp_q[i].cyc = jitter ? -1 : p + exp_q[i].cyc * CPB + CPB / 2 + 1;
    endtask

    task automatic finish_pkt(input string name);
        repeat (2 * CPB) @(posedge clk);
        #1;
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({name, "_kind"}, got_q[i].kind, exp_q[i].kind);
            check({name, "_data"}, got_q[i].data, exp_q[i].data);
            if (exp_q[i].cyc >= 0) check({name, "_cyc"}, got_q[i].cyc, exp_q[i].cyc);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int len;
        int idx0;

        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("idle_rx_byte", int'(rx_byte), 0);
        check("idle_active", int'(rx_active), 0);
        check("idle_pulses", int'({byte_valid, eop, rx_err}), 0);
        check("idle_events", got_q.size(), 0);

        new_pkt(); send_sync(); send_byte(8'hA5, 1'b1); send_eop(); idle_bits(3);
        play(1'b0); finish_pkt("sync_a5");
        check("a5_hold", int'(rx_byte), 8'hA5);

        new_pkt(); send_sync(); send_byte(8'hFF, 1'b1); send_eop(); idle_bits(3);
        check("ff_stuffed_len", sym_q.size(), 8 + 9 + 3 + 3);
        play(1'b0); finish_pkt("ff_stuff");

        // Seven decoded ones in a row (SYNC ends with a one), then garbage, then idle J.
        new_pkt(); send_sync();
        for (int i = 0; i < 6; i++) nrzi_bit(1'b1);
        exp_q.push_back('{EV_ERR, 0, sym_q.size() - 1});
        for (int i = 0; i < 6; i++) nrzi_bit(1'b0);
        idx0 = sym_q.size();
        idle_bits(10);
        exp_q.push_back('{EV_IDLE, 0, idx0 + 7});
        play(1'b0); finish_pkt("stuff_err");

        new_pkt(); send_sync();
        for (int i = 0; i < 3; i++) data_bit(1'($urandom_range(1)));
        exp_q.push_back('{EV_ERR, 0, sym_q.size()});
        send_eop(); idle_bits(3);
        play(1'b0); finish_pkt("se0_partial");

        for (int p = 0; p < 6; p++) begin
            new_pkt(); send_sync();
            len = (p == 1) ? 4 : int'($urandom_range(1, 4));
            b = 8'h00;
            for (int i = 0; i < len; i++) begin
                b = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
                send_byte(b, 1'b1);
            end
            send_eop(); idle_bits(3);
            play(p[0]); finish_pkt("rand_pkt");
            check("rand_hold", int'(rx_byte), int'(b));
        end

        new_pkt(); send_sync();
        for (int i = 0; i < 4; i++) data_bit(1'($urandom_range(1)));
        play(1'b0);
        check("rst_pre_active", int'(rx_active), 1);
        #2 n_rst = 1'b0;
        #1;
        check("rst_rx_byte", int'(rx_byte), 0);
        check("rst_active", int'(rx_active), 0);
        check("rst_pulses", int'({byte_valid, eop, rx_err}), 0);
        {d_plus_sync, d_minus_sync} = SYM_J;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        exp_q.push_back('{EV_IDLE, 0, -1});
        finish_pkt("rst_mid");

        new_pkt(); send_sync(); send_byte(8'h3C, 1'b1); send_eop(); idle_bits(3);
        play(1'b0); finish_pkt("post_rst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/usb_rx_bit_decoder.md
Name: usb_rx_bit_decoder

Overview:
- Receive-side bit decoder. Sits directly downstream of the D+/D- synchronizers:
  - D+ comes from the reset-high synchronizer.
  - D- comes from the reset-low synchronizer.
- Recovers bit timing from line edges, NRZI-decodes, removes stuffed bits, assembles LSB-first bytes and detects EOP (End Of Packet).
- Feeds the packet-level RX controller with byte strobes and status pulses.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time; even, >= 4.
- STUFF_LEN, 6, consecutive decoded 1s after which a stuffed 0 is expected.

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset
- d_plus_sync  input  1  synchronized D+ (idle/J = 1)
- d_minus_sync  input  1  synchronized D- (idle/J = 0)
- rx_byte  output  8  last assembled byte, held until next byte
- byte_valid  output  1  one-cycle pulse, rx_byte newly valid
- eop  output  1  one-cycle pulse, valid EOP completed
- rx_err  output  1  one-cycle pulse, stuff error or EOP on partial byte
- rx_active  output  1  high from packet start until return to IDLE

Behaviour:
- Clock and reset: clk drives all state; reset n_rst is asynchronous, active-low.
- Reset values: rx_byte=0x00, byte_valid=0, eop=0, rx_err=0, rx_active=0, state=IDLE, prev_level=1, d_plus_q=1, cnt=0, bit_cnt=0, ones_cnt=0.
- Line decode: J=(1,0), K=(0,1), SE0=(0,0). SE1=(1,1) is treated as J.
- Edge and timing:
  - edge = d_plus_sync != d_plus_q; d_plus_q is registered every cycle.
  - Edge detected at cycle t -> cnt=0 at t+1, then cnt increments and wraps at CLKS_PER_BIT-1.
  - Sample strobe when cnt == CLKS_PER_BIT/2-1, so the first sample falls CLKS_PER_BIT/2 cycles after the edge cycle (4 cycles by default).
  - Without edges, strobes repeat every CLKS_PER_BIT cycles.
- IDLE:
  - On a falling edge of d_plus_sync with d_minus_sync=1 (K): go to RECV, rx_active=1, prev_level=1, bit_cnt=0, ones_cnt=0.
  - SE0 in IDLE is ignored.
- RECV, at each strobe:
  - If SE0: go to EOP. If bit_cnt != 0, pulse rx_err and discard the partial byte.
  - Otherwise decoded bit = (d_plus_sync == prev_level); then prev_level = d_plus_sync.
  - If ones_cnt == STUFF_LEN:
    - Bit 0: discard it (stuffed bit), ones_cnt=0.
    - Bit 1: pulse rx_err, go to ERR.
  - Else: shift the bit into the byte MSB (LSB-first arrival). ones_cnt = bit ? ones_cnt+1 : 0. bit_cnt++.
  - When bit_cnt reaches 8: rx_byte updates and byte_valid pulses in the cycle after the strobe; bit_cnt=0.
- EOP, at each strobe:
  - SE0: count it.
  - J after >= 1 SE0 sample: pulse eop, go to IDLE, rx_active=0.
  - K, or a 3rd SE0 sample: pulse rx_err, go to ERR.
- ERR:
  - Outputs stay quiet.
  - Go to IDLE (rx_active=0) after 8 consecutive J strobes, or after SE0 followed by J.
  - No eop pulse is issued on this exit.
- Simultaneous events: byte completion and SE0 cannot occur on the same strobe. Strobe and edge in the same cycle: the strobe is processed, then cnt restarts.
- Pulse widths: byte_valid, eop and rx_err are never high for more than one consecutive cycle.
- Reset mid-packet: immediate return to reset values; no pulse is emitted.

Optional Feature:
- RX_SYNC_CHECK_EN
- Defined:
  - The first assembled byte of each packet must be 0x80 (SYNC); it is consumed without a byte_valid pulse.
  - Any other value: pulse rx_err, go to ERR.
- Undefined: the SYNC byte is delivered as an ordinary byte (byte_valid with rx_byte=0x80).

Test Plan:
- Reset with lines J, no activity for 100 cycles -> all outputs 0, rx_active=0, rx_byte=0x00.
- Send NRZI SYNC KJKJKJKK, then byte 0xA5, then SE0,SE0,J:
  - Macro undefined: byte_valid pulses twice with rx_byte=0x80 then 0xA5, followed by an eop pulse.
  - Macro defined: only 0xA5 is delivered.
- Byte 0xFF after SYNC, with stuffed 0 inserted after six 1s -> rx_byte=0xFF, no rx_err; stuffed bit absent from the byte.
- Seven consecutive decoded 1s (stuff violation) -> rx_err pulse on the 7th strobe; no further byte_valid until ERR exits after 8 J bit times.
- SE0 after 3 bits of a byte -> rx_err pulse, partial byte discarded; eop pulses after SE0,SE0,J.
- Edge jitter of +/-1 cycle per bit over a 4-byte packet -> all bytes correct. Also: n_rst asserted mid-byte -> immediate reset values, no pulse.
